alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. It executes the shared instruction-set ALU opcodes on WIDTH-bit operands under a start/busy/done handshake. ADD, logic, shift and compare complete in one cycle. MUL (shift-add) and DIV (restoring) run iteratively over WIDTH cycles. It sits between the register file and the controller, which issues `start` and consumes `done`, ALU_OUTPUT, REM and ALU_FLAGS.

---
 rtl/alu_seq_if.sv | 64 ++++++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: opcode map, flag codes and the controller <-> ALU handshake bus.
//   master (controller): drives start, ALU_OpCode, A, B; reads busy, done,
//                        ALU_OUTPUT, REM, ALU_FLAGS.
//   slave  (ALU)       : the mirror image.
package alu_seq_pkg;
  localparam logic [4:0] OP_START   = 5'd0;
  localparam logic [4:0] OP_END     = 5'd1;
  localparam logic [4:0] OP_WAIT    = 5'd2;
  localparam logic [4:0] OP_ADD     = 5'd3;
  localparam logic [4:0] OP_SUB     = 5'd4;
  localparam logic [4:0] OP_MUL     = 5'd5;
  localparam logic [4:0] OP_DIV     = 5'd6;
  localparam logic [4:0] OP_CMPLT   = 5'd7;
  localparam logic [4:0] OP_CMPGT   = 5'd8;
  localparam logic [4:0] OP_CMPLE   = 5'd9;
  localparam logic [4:0] OP_CMPGE   = 5'd10;
  localparam logic [4:0] OP_CMPEQ   = 5'd11;
  localparam logic [4:0] OP_CMPNE   = 5'd12;
  localparam logic [4:0] OP_ANDB    = 5'd13;
  localparam logic [4:0] OP_ORB     = 5'd14;
  localparam logic [4:0] OP_XORB    = 5'd15;
  localparam logic [4:0] OP_NOTB    = 5'd16;
  localparam logic [4:0] OP_CPY     = 5'd17;
  localparam logic [4:0] OP_TWOCOMP = 5'd18;
  localparam logic [4:0] OP_LSLN    = 5'd19;
  localparam logic [4:0] OP_LSRN    = 5'd20;
  localparam logic [4:0] OP_LSL     = 5'd21;
  localparam logic [4:0] OP_LSR     = 5'd22;
  localparam logic [4:0] OP_ASL     = 5'd23;
  localparam logic [4:0] OP_ASR     = 5'd24;
  localparam logic [4:0] OP_RSL     = 5'd25;
  localparam logic [4:0] OP_RSR     = 5'd26;
  localparam logic [4:0] OP_MOD     = 5'd27;
  localparam logic [4:0] OP_DISPB   = 5'd28;
  localparam logic [4:0] OP_DISPH   = 5'd29;
  localparam logic [4:0] OP_LDR     = 5'd30;
  localparam logic [4:0] OP_STR     = 5'd31;

  localparam logic [2:0] FL_NONE  = 3'd0;
  localparam logic [2:0] FL_TRUE  = 3'd1;
  localparam logic [2:0] FL_FALSE = 3'd2;
  localparam logic [2:0] FL_OVF   = 3'd3;
  localparam logic [2:0] FL_NEG   = 3'd4;
  localparam logic [2:0] FL_INV   = 3'd5;
  localparam logic [2:0] FL_EVEN  = 3'd6;
  localparam logic [2:0] FL_ODD   = 3'd7;
endpackage

interface alu_seq_if #(parameter int WIDTH = 14);
  logic             start;
  logic [4:0]       ALU_OpCode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALU_OUTPUT;
  logic [WIDTH-1:0] REM;
  logic [2:0]       ALU_FLAGS;

  modport master (output start, ALU_OpCode, A, B,
                  input  busy, done, ALU_OUTPUT, REM, ALU_FLAGS);
  modport slave  (input  start, ALU_OpCode, A, B,
                  output busy, done, ALU_OUTPUT, REM, ALU_FLAGS);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with start/busy/done handshake.
//   clk      : rising-edge clock
//   rstFlags : asynchronous active-high reset
//   bus      : alu_seq_if.slave (start/opcode/operands in; busy/done/result,
//              remainder and flag code out)
// Single-cycle ops complete on the accepting edge. MUL (shift-add) and
// DIV (restoring) take WIDTH iterations; outputs land on edge WIDTH.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter bit MUL_SAT = 1'b0
) (
  input  logic      clk,
  input  logic      rstFlags,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WL = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     divq_q, divr_q, divisor_q;
  logic [WIDTH-1:0]     out_q, rem_q;
  logic [2:0]           flg_q;
  logic                 done_q, busy;

  logic [4:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             last, go_mul, go_div;

  assign op     = bus.ALU_OpCode;
  assign a      = bus.A;
  assign b      = bus.B;
  assign last   = (cnt_q == CW'(WIDTH-1));
  assign go_mul = (op == OP_MUL);
  assign go_div = (op == OP_DIV) && (|b);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rstFlags) begin
    if (rstFlags) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        if (go_mul)      state_d = S_MUL;
        else if (go_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb busy = (state_q != S_IDLE);

  // ---- single-cycle datapath ----
  logic [WIDTH-1:0] sc_res, sc_rem;
  logic [2:0]       sc_flg;
  logic             sc_keep;  // compares leave ALU_OUTPUT/REM untouched
  logic [WIDTH:0]   sum, twos;

  always_comb begin
    sc_res  = '0;
    sc_rem  = '0;
    sc_flg  = FL_NONE;
    sc_keep = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    twos    = {1'b0, ~a} + (WIDTH+1)'(1);
    case (op)
      OP_ADD:     begin sc_res = sum[WIDTH-1:0]; sc_flg = sum[WIDTH] ? FL_OVF : FL_NONE; end
      OP_SUB:     begin sc_res = a - b; sc_flg = (a < b) ? FL_NEG : FL_NONE; end
      OP_DIV:     begin sc_res = a; sc_flg = FL_INV; end  // only reached with B=0
      OP_CMPLT:   begin sc_keep = 1'b1; sc_flg = (a <  b) ? FL_TRUE : FL_FALSE; end
      OP_CMPGT:   begin sc_keep = 1'b1; sc_flg = (a >  b) ? FL_TRUE : FL_FALSE; end
      OP_CMPLE:   begin sc_keep = 1'b1; sc_flg = (a <= b) ? FL_TRUE : FL_FALSE; end
      OP_CMPGE:   begin sc_keep = 1'b1; sc_flg = (a >= b) ? FL_TRUE : FL_FALSE; end
      OP_CMPEQ:   begin sc_keep = 1'b1; sc_flg = (a == b) ? FL_TRUE : FL_FALSE; end
      OP_CMPNE:   begin sc_keep = 1'b1; sc_flg = (a != b) ? FL_TRUE : FL_FALSE; end
      OP_ANDB:    sc_res = a & b;
      OP_ORB:     sc_res = a | b;
      OP_XORB:    sc_res = a ^ b;
      OP_NOTB:    sc_res = ~a;
      OP_CPY:     sc_res = a;
      // carry out of ~A+1 only happens for A=0
      OP_TWOCOMP: begin sc_res = twos[WIDTH-1:0]; sc_flg = twos[WIDTH] ? FL_OVF : FL_NONE; end
      OP_LSLN:    sc_res = (b >= WL) ? '0 : (a << b);
      OP_LSRN:    sc_res = (b >= WL) ? '0 : (a >> b);
      OP_LSL,
      OP_ASL:     sc_res = {a[WIDTH-2:0], 1'b0};
      OP_LSR:     sc_res = {1'b0, a[WIDTH-1:1]};
      OP_ASR:     sc_res = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_RSL:     sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_RSR:     sc_res = {a[0], a[WIDTH-1:1]};
      OP_MOD:     begin sc_res = {{(WIDTH-1){1'b0}}, a[0]}; sc_flg = a[0] ? FL_ODD : FL_EVEN; end
      default:    ;  // control/IO opcodes: zero result, no flag
    endcase
  end

  // ---- iterative datapath ----
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH:0]   rsh;       // WIDTH+1-bit partial remainder, never overflows
  logic [WIDTH-1:0] div_r_d, div_q_d;

  always_comb begin
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_ovf = |acc_d[2*WIDTH-1:WIDTH];
    mul_res = (MUL_SAT && mul_ovf) ? '1 : acc_d[WIDTH-1:0];
    rsh     = {divr_q, divq_q[WIDTH-1]};
    div_q_d = {divq_q[WIDTH-2:0], 1'b0};
    div_r_d = rsh[WIDTH-1:0];
    if (rsh >= {1'b0, divisor_q}) begin
      div_r_d    = WIDTH'(rsh - {1'b0, divisor_q});
      div_q_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstFlags) begin
    if (rstFlags) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      divq_q    <= '0;
      divr_q    <= '0;
      divisor_q <= '0;
      out_q     <= '0;
      rem_q     <= '0;
      flg_q     <= FL_NONE;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          cnt_q <= '0;
          if (go_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
          end else if (go_div) begin
            divq_q    <= a;   // dividend shifts out as quotient shifts in
            divr_q    <= '0;
            divisor_q <= b;
          end else begin
            if (!sc_keep) begin
              out_q <= sc_res;
              rem_q <= sc_rem;
            end
            flg_q  <= sc_flg;
            done_q <= 1'b1;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            out_q  <= mul_res;
            rem_q  <= '0;
            flg_q  <= mul_ovf ? FL_OVF : FL_NONE;
            done_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        S_DIV: begin
          divq_q <= div_q_d;
          divr_q <= div_r_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            out_q  <= div_q_d;
            rem_q  <= div_r_d;
            flg_q  <= FL_NONE;
            done_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.ALU_OUTPUT = out_q;
  assign bus.REM        = rem_q;
  assign bus.ALU_FLAGS  = flg_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int W = 14;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rstFlags = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) ifw ();   // wrapping MUL
  alu_seq_if #(.WIDTH(W)) ifs ();   // saturating MUL

  alu_seq #(.WIDTH(W), .MUL_SAT(1'b0)) dut_wrap (.clk(clk), .rstFlags(rstFlags), .bus(ifw.slave));
  alu_seq #(.WIDTH(W), .MUL_SAT(1'b1)) dut_sat  (.clk(clk), .rstFlags(rstFlags), .bus(ifs.slave));

  assign ifs.start      = ifw.start;
  assign ifs.ALU_OpCode = ifw.ALU_OpCode;
  assign ifs.A          = ifw.A;
  assign ifs.B          = ifw.B;

  typedef struct { int out; int rem; int flg; int cyc; } exp_t;
  exp_t q0[$], q1[$];
  int mout[2], mrem[2];
  int cyc = 0;
  int busy_lo = 1, busy_hi = 0;
  int n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model from the instruction rules; compares leave out/rem alone.
  function automatic void model(input int op, input int a, input int b, input bit sat,
                                inout int out, inout int rem, output int flg);
    int p;
    flg = 0;
    if (op >= 7 && op <= 12) begin
      bit c;
      case (op)
        7:  c = a <  b;
        8:  c = a >  b;
        9:  c = a <= b;
        10: c = a >= b;
        11: c = a == b;
        default: c = a != b;
      endcase
      flg = c ? 1 : 2;
      return;
    end
    rem = 0;
    case (op)
      3:  begin out = (a + b) % M; flg = (a + b >= M) ? 3 : 0; end
      4:  begin out = (a - b + M) % M; flg = (a < b) ? 4 : 0; end
      5:  begin p = a * b;
                if (p >= M) begin flg = 3; out = sat ? M - 1 : p % M; end
                else out = p; end
      6:  if (b == 0) begin out = a; flg = 5; end
          else begin out = a / b; rem = a % b; end
      13: out = a & b;
      14: out = a | b;
      15: out = a ^ b;
      16: out = M - 1 - a;
      17: out = a;
      18: begin out = (M - a) % M; flg = (a == 0) ? 3 : 0; end
      19: out = (b >= W) ? 0 : (a << b) % M;
      20: out = (b >= W) ? 0 : a >> b;
      21, 23: out = (a * 2) % M;
      22: out = a / 2;
      24: out = a / 2 + ((a >= M / 2) ? M / 2 : 0);
      25: out = (a * 2) % M + a / (M / 2);
      26: out = a / 2 + (a % 2) * (M / 2);
      27: begin out = a % 2; flg = (a % 2) ? 7 : 6; end
      default: out = 0;
    endcase
  endfunction

  // mode 0: wait out a multi-cycle op; 1: also wiggle start/A/B while busy;
  // 2: return right after acceptance.
  task automatic issue(input int op, input int a, input int b, input int mode);
    exp_t e;
    int f, e0;
    bit multi;
    @(negedge clk);
    ifw.start = 1'b1; ifw.ALU_OpCode = 5'(op); ifw.A = W'(a); ifw.B = W'(b);
    @(posedge clk); #1;
    ifw.start = 1'b0;
    e0 = cyc;
    multi = (op == 5) || (op == 6 && b != 0);
    for (int id = 0; id < 2; id++) begin
      model(op, a, b, id == 1, mout[id], mrem[id], f);
      e.out = mout[id]; e.rem = mrem[id]; e.flg = f; e.cyc = e0 + (multi ? W : 0);
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (multi) begin
      busy_lo = e0; busy_hi = e0 + W - 1;
      if (mode == 1) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          ifw.start = 1'b1; ifw.ALU_OpCode = OP_ADD;
          ifw.A = W'($urandom); ifw.B = W'($urandom);
        end
        @(negedge clk) ifw.start = 1'b0;
      end
      if (mode != 2) while (cyc < e0 + W) @(posedge clk);
    end
  endtask

  // Monitor: busy window every cycle, scoreboard pop on every done.
  always @(negedge clk) begin : mon
    logic d, bz;
    int o, r, f;
    exp_t e;
    bit have;
    if (!rstFlags) begin
      for (int id = 0; id < 2; id++) begin
        d  = (id == 0) ? ifw.done : ifs.done;
        bz = (id == 0) ? ifw.busy : ifs.busy;
        o  = int'((id == 0) ? ifw.ALU_OUTPUT : ifs.ALU_OUTPUT);
        r  = int'((id == 0) ? ifw.REM : ifs.REM);
        f  = int'((id == 0) ? ifw.ALU_FLAGS : ifs.ALU_FLAGS);
        chk("busy", int'(bz), int'(cyc >= busy_lo && cyc <= busy_hi));
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (id == 0) ? q0[0] : q1[0];
        if (d) begin
          if (!have) fail("spurious_done", 1, 0);
          else begin
            chk("done_cycle", cyc, e.cyc);
            chk("ALU_OUTPUT", o, e.out);
            chk("REM", r, e.rem);
            chk("ALU_FLAGS", f, e.flg);
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
        end else if (have && cyc >= e.cyc) begin
          fail("missing_done", cyc, e.cyc);
          if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_out_w"}, int'(ifw.ALU_OUTPUT), 0);
    chk({tag, "_rem_w"}, int'(ifw.REM), 0);
    chk({tag, "_flg_w"}, int'(ifw.ALU_FLAGS), 0);
    chk({tag, "_done_w"}, int'(ifw.done), 0);
    chk({tag, "_busy_w"}, int'(ifw.busy), 0);
    chk({tag, "_out_s"}, int'(ifs.ALU_OUTPUT), 0);
    chk({tag, "_done_s"}, int'(ifs.done), 0);
    chk({tag, "_busy_s"}, int'(ifs.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a, b;
    ifw.start = 1'b0; ifw.ALU_OpCode = '0; ifw.A = '0; ifw.B = '0;
    mout = '{0, 0}; mrem = '{0, 0};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rstFlags = 1'b0;

    issue(OP_ADD, 16383, 1, 0);
    issue(OP_MUL, 200, 100, 0);
    issue(OP_DIV, 100, 7, 0);
    issue(OP_DIV, 100, 0, 0);
    issue(OP_MUL, 200, 100, 1);
    issue(OP_ASR, 'h2000, 0, 0);
    issue(OP_LSLN, 1, 14, 0);
    issue(OP_RSR, 1, 0, 0);
    issue(OP_SUB, 5, 9, 0);
    issue(OP_CMPGE, 9, 9, 0);
    issue(OP_TWOCOMP, 0, 0, 0);
    issue(OP_MOD, 6, 0, 0);

    // Reset in the middle of a DIV: no done, everything back to zero.
    issue(OP_DIV, 100, 7, 2);
    repeat (6) @(posedge clk);
    #1 rstFlags = 1'b1;
    q0.delete(); q1.delete();
    mout = '{0, 0}; mrem = '{0, 0};
    busy_lo = 1; busy_hi = 0;
    @(negedge clk);
    chk_zero("midreset");
    @(negedge clk) rstFlags = 1'b0;
    issue(OP_ADD, 3, 4, 0);

    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 31));
      a  = int'($urandom_range(0, M - 1));
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, M - 1));
      issue(op, a, b, ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    chk("drain_wrap", q0.size(), 0);
    chk("drain_sat", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
